// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data stage. One fixed-latency access runs at a time. Data has
// priority, but a starvation counter lets fetch through after STARVE_LIMIT
// consecutive data grants made while fetch was waiting.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_rdata,
  output logic        fetch_stall,
  input  logic        data_req,
  input  logic        data_rw,
  input  logic        data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic        size_q, size_d;
  logic [31:0] fetch_rdata_q, fetch_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        grant_fetch, grant_data;

  // Arbitration: data wins unless fetch has waited through STARVE_LIMIT data grants
  always_comb begin
    grant_fetch = fetch_req & (~data_req | (starve_q == STARVE_MAX));
    grant_data  = data_req & ~grant_fetch;
  end

  // Next-state logic: grant and latch in IDLE, count down in ACCESS, capture on the last cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    starve_d      = starve_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rw_d          = rw_q;
    size_d        = size_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d  = ACCESS;
          cnt_d    = LAT_LOAD;
          owner_d  = 1'b1;
          addr_d   = data_addr;
          wdata_d  = data_wdata;
          rw_d     = data_rw;
          size_d   = data_size;
          if (fetch_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (grant_fetch) begin
          state_d  = ACCESS;
          cnt_d    = LAT_LOAD;
          owner_d  = 1'b0;
          addr_d   = fetch_addr;
          wdata_d  = 32'h0;
          rw_d     = 1'b0;
          size_d   = 1'b1;
          starve_d = 4'd0;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (owner_q) begin
            if (!rw_q) begin
              data_rdata_d = size_q ? mem_rdata : {24'h0, mem_rdata[7:0]};
            end
          end else begin
            fetch_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      starve_q      <= 4'd0;
      owner_q       <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      rw_q          <= 1'b0;
      size_q        <= 1'b0;
      fetch_rdata_q <= 32'h0;
      data_rdata_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      starve_q      <= starve_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rw_q          <= rw_d;
      size_q        <= size_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  // Memory-side outputs are decoded from registered state only, so they are glitch-free
  assign mem_en    = (state_q == ACCESS);
  assign mem_rw    = mem_en & rw_q;
  assign mem_size  = mem_en & size_q;
  assign mem_addr  = mem_en ? addr_q : 32'h0;
  assign mem_wdata = mem_en ? wdata_q : 32'h0;

  assign fetch_done  = (state_q == DONE) & ~owner_q;
  assign data_done   = (state_q == DONE) & owner_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign fetch_stall = fetch_req & ~fetch_done;
  assign data_stall  = data_req & ~data_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Each requester pushes its expected
// access into its own scoreboard queue; a monitor snapshots the memory bus
// during mem_en and pops/compares on every done pulse.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SLIM = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        fetch_stall;
  logic        data_req;
  logic        data_rw;
  logic        data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        mem_en;
  logic        mem_rw;
  logic        mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic        size;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    byte who;
    int  cyc;
  } ev_t;

  req_t fq[$];
  req_t dq[$];
  ev_t  log_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int en_run = 0;
  logic [31:0] exp_fetch_rdata = 32'h0;
  logic [31:0] exp_data_rdata = 32'h0;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .fetch_rdata(fetch_rdata), .fetch_stall(fetch_stall),
    .data_req(data_req), .data_rw(data_rw), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_done(data_done),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: contents are a fixed function of address
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hE3A0_1005;
      32'h0000_0020: return 32'h1234_5678;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endcase
  endfunction

  // Read data is only valid in the last enable cycle; garbage elsewhere
  always @(posedge clk) en_run <= mem_en ? en_run + 1 : 0;
  assign mem_rdata = (mem_en && en_run == LAT - 1) ? mem_model(mem_addr) : 32'hBAD0_BAD0;

  // Monitor: snapshot bus during the access, score it on the done pulse
  initial begin
    int          en_cycles;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_rw;
    logic        s_size;
    req_t        r;
    logic [31:0] m;
    logic [31:0] exp;
    ev_t         e;
    en_cycles = 0;
    s_addr = 0; s_wdata = 0; s_rw = 0; s_size = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_cycles = 0;
      end else begin
        if (mem_en) begin
          if (en_cycles == 0) begin
            s_addr = mem_addr; s_wdata = mem_wdata; s_rw = mem_rw; s_size = mem_size;
          end else begin
            checks++;
            if ({mem_addr, mem_wdata, mem_rw, mem_size} !== {s_addr, s_wdata, s_rw, s_size}) begin
              errors++;
              $display("[TB] FAIL bus_stable got addr=%h rw=%b got_first=%h", mem_addr, mem_rw, s_addr);
            end
          end
          en_cycles++;
        end
        if (fetch_done || data_done) begin
          checks++;
          if (fetch_done && data_done) begin
            errors++;
            $display("[TB] FAIL both_done got fetch_done=1 data_done=1 exp one only");
          end
          checks++;
          if (en_cycles !== LAT) begin
            errors++;
            $display("[TB] FAIL en_cycles got %0d exp %0d", en_cycles, LAT);
          end
          if (fetch_done) begin
            checks++;
            if (fq.size() == 0) begin
              errors++;
              $display("[TB] FAIL fetch_done_unexpected got pulse exp none");
            end else begin
              r = fq.pop_front();
              checks++;
              if ({s_addr, s_rw, s_size} !== {r.addr, 1'b0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL fetch_bus got addr=%h rw=%b size=%b exp addr=%h rw=0 size=1",
                         s_addr, s_rw, s_size, r.addr);
              end
              exp_fetch_rdata = mem_model(r.addr);
              checks++;
              if (fetch_rdata !== exp_fetch_rdata) begin
                errors++;
                $display("[TB] FAIL fetch_rdata got %h exp %h", fetch_rdata, exp_fetch_rdata);
              end
              e.who = "F"; e.cyc = cycle;
              log_q.push_back(e);
            end
          end
          if (data_done) begin
            checks++;
            if (dq.size() == 0) begin
              errors++;
              $display("[TB] FAIL data_done_unexpected got pulse exp none");
            end else begin
              r = dq.pop_front();
              checks++;
              if ({s_addr, s_rw, s_size, s_wdata} !== {r.addr, r.rw, r.size, r.wdata}) begin
                errors++;
                $display("[TB] FAIL data_bus got addr=%h rw=%b size=%b wdata=%h exp addr=%h rw=%b size=%b wdata=%h",
                         s_addr, s_rw, s_size, s_wdata, r.addr, r.rw, r.size, r.wdata);
              end
              m = mem_model(r.addr);
              if (r.rw) exp = exp_data_rdata;
              else if (r.size) exp = m;
              else exp = {24'h0, m[7:0]};
              exp_data_rdata = exp;
              checks++;
              if (data_rdata !== exp_data_rdata) begin
                errors++;
                $display("[TB] FAIL data_rdata got %h exp %h", data_rdata, exp_data_rdata);
              end
              e.who = "D"; e.cyc = cycle;
              log_q.push_back(e);
            end
          end
          en_cycles = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    fetch_req = 0; fetch_addr = 0;
    data_req = 0; data_rw = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    fq.delete();
    dq.delete();
    exp_fetch_rdata = 32'h0;
    exp_data_rdata = 32'h0;
  endtask

  task automatic wait_fetch_done();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (fetch_done) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("[TB] FAIL fetch_timeout got no fetch_done exp pulse");
        break;
      end
    end
  endtask

  task automatic wait_data_done();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (data_done) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("[TB] FAIL data_timeout got no data_done exp pulse");
        break;
      end
    end
  endtask

  // Requester models: raise req, hold fields until done, drop in the following IDLE cycle
  task automatic fetch_access(input logic [31:0] addr);
    req_t r;
    r.addr = addr; r.rw = 1'b0; r.size = 1'b1; r.wdata = 32'h0;
    fq.push_back(r);
    fetch_req = 1'b1;
    fetch_addr = addr;
    wait_fetch_done();
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
  endtask

  task automatic data_access(input logic rw, input logic size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    req_t r;
    r.addr = addr; r.rw = rw; r.size = size; r.wdata = wdata;
    dq.push_back(r);
    data_req = 1'b1;
    data_rw = rw; data_size = size; data_addr = addr; data_wdata = wdata;
    wait_data_done();
    @(posedge clk);
    #1;
    data_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_rw, mem_size, fetch_done, data_done, fetch_stall, data_stall} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b exp 0000000",
               {mem_en, mem_rw, mem_size, fetch_done, data_done, fetch_stall, data_stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, fetch_rdata, data_rdata} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got addr=%h wdata=%h frd=%h drd=%h exp all 0",
               mem_addr, mem_wdata, fetch_rdata, data_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_fetch();
    req_t r;
    r.addr = 32'h10; r.rw = 1'b0; r.size = 1'b1; r.wdata = 32'h0;
    fq.push_back(r);
    fetch_req = 1'b1;
    fetch_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({mem_en, fetch_stall} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL fetch_T got en,stall=%b exp 01", {mem_en, fetch_stall});
    end
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_en, mem_rw, mem_size, mem_addr, fetch_done} !== {3'b101, 32'h10, 1'b0}) begin
        errors++;
        $display("[TB] FAIL fetch_access%0d got en=%b rw=%b size=%b addr=%h done=%b exp 1 0 1 00000010 0",
                 i, mem_en, mem_rw, mem_size, mem_addr, fetch_done);
      end
    end
    @(negedge clk);
    checks++;
    if ({fetch_done, fetch_stall, mem_en, fetch_rdata} !== {3'b100, 32'hE3A0_1005}) begin
      errors++;
      $display("[TB] FAIL fetch_done_cycle got done=%b stall=%b en=%b rdata=%h exp 1 0 0 e3a01005",
               fetch_done, fetch_stall, mem_en, fetch_rdata);
    end
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({fetch_done, mem_en, fetch_rdata} !== {2'b00, 32'hE3A0_1005}) begin
      errors++;
      $display("[TB] FAIL fetch_after got done=%b en=%b rdata=%h exp 0 0 e3a01005",
               fetch_done, mem_en, fetch_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_store();
    data_access(1'b0, 1'b0, 32'h20, 32'h0);
    checks++;
    if (data_rdata !== 32'h0000_0078) begin
      errors++;
      $display("[TB] FAIL byte_load got %h exp 00000078", data_rdata);
    end
    data_access(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    checks++;
    if (data_rdata !== 32'h0000_0078) begin
      errors++;
      $display("[TB] FAIL store_keeps_rdata got %h exp 00000078", data_rdata);
    end
    data_access(1'b0, 1'b1, 32'h20, 32'h0);
  endtask

  task automatic test_simultaneous();
    log_q.delete();
    fork
      fetch_access(32'h10);
      data_access(1'b0, 1'b1, 32'h20, 32'h0);
    join
    checks++;
    if (log_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL simul_count got %0d exp 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].who != "D" || log_q[1].who != "F" || log_q[1].cyc - log_q[0].cyc != LAT + 2) begin
        errors++;
        $display("[TB] FAIL simul_order got %c,%c gap %0d exp D,F gap %0d",
                 log_q[0].who, log_q[1].who, log_q[1].cyc - log_q[0].cyc, LAT + 2);
      end
    end
  endtask

  task automatic test_starvation();
    string got;
    string exp;
    apply_reset();
    log_q.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) data_access(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h0);
      end
      begin
        fetch_access(32'h200);
        fetch_access(32'h204);
        @(posedge clk);
        #1;
        fetch_access(32'h208);
      end
    join
    got = "";
    foreach (log_q[i]) got = $sformatf("%s%c", got, log_q[i].who);
    exp = "DDDFDDDFDDDDFDD";
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL starve_order got %s exp %s", got, exp);
    end
  endtask

  task automatic test_reset_abort();
    data_access(1'b0, 1'b1, 32'h20, 32'h0);
    data_req = 1'b1; data_rw = 1'b0; data_size = 1'b1; data_addr = 32'h44; data_wdata = 32'h0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_in_access got mem_en=%b exp 1", mem_en);
    end
    reset = 1'b1;
    data_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_data_rdata = 32'h0;
    exp_fetch_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_rw, mem_size, mem_addr, mem_wdata, data_done, fetch_done, data_rdata, fetch_rdata}
        !== 133'h0) begin
      errors++;
      $display("[TB] FAIL abort_outputs got en=%b addr=%h done=%b drd=%h frd=%h exp all 0",
               mem_en, mem_addr, data_done, data_rdata, fetch_rdata);
    end
    repeat (4) @(posedge clk);
    #1;
    data_access(1'b0, 1'b1, 32'h20, 32'h0);
    checks++;
    if (data_rdata !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL after_abort got %h exp 12345678", data_rdata);
    end
  endtask

  task automatic test_drop_mid_access();
    req_t r;
    r.addr = 32'h20; r.rw = 1'b0; r.size = 1'b0; r.wdata = 32'h0;
    dq.push_back(r);
    data_req = 1'b1; data_rw = 1'b0; data_size = 1'b0; data_addr = 32'h20; data_wdata = 32'h0;
    @(posedge clk);
    #1;
    data_req = 1'b0;
    data_addr = 32'hFFFF_FFF0;
    data_size = 1'b1;
    wait_data_done();
    checks++;
    if (data_rdata !== 32'h0000_0078) begin
      errors++;
      $display("[TB] FAIL drop_rdata got %h exp 00000078", data_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_byte_store();
    test_simultaneous();
    test_starvation();
    test_reset_abort();
    test_drop_mid_access();
    repeat (4) @(posedge clk);
    checks++;
    if (fq.size() + dq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending exp 0", fq.size() + dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the instruction-fetch stage and the data-memory stage of the ARM pipeline. It accepts word-read requests from fetch and read/write requests (word or byte) from the data stage, driven by the control unit's `mem_enable`, `mem_rw` and `mem_size` decode. It runs one fixed-latency access at a time, returns read data with a one-cycle done pulse, and drives the stall signals the pipeline uses to freeze the requesting stages.

## Interface
- `MEM_LATENCY`, 2: cycles the memory enable is held per access; legal range 1..15.
- `STARVE_LIMIT`, 3: consecutive data grants allowed while fetch is waiting; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  fetch requests a word read.
- `fetch_addr`  in  32  fetch byte address.
- `fetch_done`  out  1  one-cycle pulse; `fetch_rdata` valid.
- `fetch_rdata`  out  32  fetched instruction word.
- `fetch_stall`  out  1  `fetch_req & ~fetch_done`.
- `data_req`  in  1  data-stage request (control unit `mem_enable`).
- `data_rw`  in  1  1 = write (store), 0 = read (load).
- `data_size`  in  1  1 = word, 0 = byte.
- `data_addr`  in  32  data byte address.
- `data_wdata`  in  32  store data.
- `data_done`  out  1  one-cycle pulse; access complete.
- `data_rdata`  out  32  load data. Byte loads are zero-extended from `mem_rdata[7:0]`.
- `data_stall`  out  1  `data_req & ~data_done`.
- `mem_en`  out  1  memory enable.
- `mem_rw`  out  1  1 = write.
- `mem_size`  out  1  1 = word, 0 = byte.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid in the last `mem_en` cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If any request is pending, grant one requester. Latch its address, write data, rw and size into internal registers, record the owner, load the latency counter with `MEM_LATENCY-1`, and go to ACCESS.
- **Arbitration:** data wins over fetch, except when `starve_cnt == STARVE_LIMIT` and `fetch_req=1`; then fetch wins.
- **`starve_cnt` (4 bits):**
  - Increments on each data grant made while `fetch_req=1`, saturating at `STARVE_LIMIT`.
  - Clears on a fetch grant.
  - Clears on a data grant made while `fetch_req=0`.
- **ACCESS:**
  - `mem_en=1`. `mem_addr`, `mem_wdata`, `mem_rw` and `mem_size` come from the latched registers.
  - A fetch access always drives `mem_rw=0`, `mem_size=1`.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: capture `mem_rdata` into the owner's rdata register (byte zero-extension applies to data reads only), then go to DONE.
- **DONE:**
  - `mem_en=0`. The owner's done output is 1 for exactly this cycle.
  - The rdata register holds its value until the next capture for that owner.
  - Return to IDLE.
- A write access leaves `data_rdata` unchanged.
- Requesters hold req and all fields stable until their done pulse. Deasserting req during ACCESS does not abort the access; done still pulses. Changes to fields after the grant are ignored.
- **Reset:**
  - State goes to IDLE; `starve_cnt=0`; counter=0.
  - All outputs are 0, including the rdata registers and the `mem_*` outputs.
  - Reset asserted mid-access abandons the access; no done pulse is issued.

## Timing
- Grant decision in IDLE cycle T (combinational on req, registered into the state).
- `mem_en=1` for cycles T+1 .. T+`MEM_LATENCY`.
- Done pulse and valid rdata at cycle T+`MEM_LATENCY`+1.
- IDLE at T+`MEM_LATENCY`+2, where the next grant can occur.
- Per-access occupancy is `MEM_LATENCY`+2 cycles. No back-to-back overlap.
- `mem_*` outputs are registered/state-decoded and glitch-free relative to `clk`. `mem_addr`/`mem_wdata` read 0 outside ACCESS.
- Stalls are combinational from req and done. The stalled stage releases in the done cycle.

## Test plan
- **Single fetch:** `MEM_LATENCY=2`, `fetch_req` with addr `0x00000010`, memory returns `0xE3A01005` -> `mem_en` high 2 cycles, `mem_rw=0`, `mem_size=1`, `fetch_done` pulses at T+3 with `fetch_rdata=0xE3A01005`.
- **Byte load and word store:**
  - Load with `data_size=0`, `mem_rdata=0x12345678` -> `data_rdata=0x00000078`.
  - Store with addr `0x40`, wdata `0xDEADBEEF`, `data_size=1` -> `mem_rw=1`, `mem_wdata=0xDEADBEEF` while `mem_en`; `data_rdata` unchanged.
- **Simultaneous requests:** `fetch_req` and `data_req` both asserted in IDLE -> data served first; fetch granted in the IDLE cycle after `data_done`.
- **Starvation guard:** `STARVE_LIMIT=3`, `data_req` held continuously with `fetch_req` high -> exactly 3 data accesses, then one fetch access, then data resumes with `starve_cnt=0`.
- **Reset and abort:**
  - Reset asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, no done pulse, and a new request is granted normally afterward.
  - `data_req` dropped mid-ACCESS -> access completes and `data_done` still pulses.
